// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with saturating direction counters
// Combinational lookup on the fetch PC; registered update from branch resolution.
module branch_predictor #(
  parameter int BTB_DEPTH = 16,
  parameter int CTR_BITS  = 2,
  parameter int MODE      = 1,
  parameter int STAT_W    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              lookup_en,
  input  logic [31:0]       lookup_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              upd_en,
  input  logic [31:0]       upd_pc,
  input  logic              upd_is_cond,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_pred_taken,
  input  logic [31:0]       upd_pred_target,
  output logic              mispredict,
  output logic [31:0]       redirect_pc,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [STAT_W-1:0]   STAT_MAX = {STAT_W{1'b1}};

  logic [BTB_DEPTH-1:0]                valid_q;
  logic [BTB_DEPTH-1:0][TAG_W-1:0]     tag_q;
  logic [BTB_DEPTH-1:0][31:0]          target_q;
  logic [BTB_DEPTH-1:0][CTR_BITS-1:0]  ctr_q;
  logic [BTB_DEPTH-1:0]                is_cond_q;

  logic [IDX_W-1:0]    lk_idx;
  logic [TAG_W-1:0]    lk_tag;
  logic                lk_hit;
  logic                lk_dir;

  logic [IDX_W-1:0]    up_idx;
  logic [TAG_W-1:0]    up_tag;
  logic                up_hit;
  logic [CTR_BITS-1:0] up_ctr;
  logic [CTR_BITS-1:0] up_ctr_next;
  logic [31:0]         upd_pc_plus4;

  // Lookup side: reads the pre-update table contents, no bypass from the update port.
  always_comb begin
    lk_idx      = lookup_pc[IDX_W+1:2];
    lk_tag      = lookup_pc[31:IDX_W+2];
    lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_dir      = is_cond_q[lk_idx] ? ctr_q[lk_idx][CTR_BITS-1] : 1'b1;
    pred_taken  = (MODE != 0) && !RST && lookup_en && lk_hit && lk_dir;
    pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + 32'd4;
  end

  always_comb begin
    up_idx       = upd_pc[IDX_W+1:2];
    up_tag       = upd_pc[31:IDX_W+2];
    up_hit       = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_ctr       = ctr_q[up_idx];
    upd_pc_plus4 = upd_pc + 32'd4;
    up_ctr_next  = up_ctr;
    if (upd_taken) begin
      if (up_ctr != CTR_MAX) up_ctr_next = up_ctr + CTR_BITS'(1);
    end else begin
      if (up_ctr != '0) up_ctr_next = up_ctr - CTR_BITS'(1);
    end
  end

  always_comb begin
    mispredict  = !RST && upd_en &&
                  ((upd_taken != upd_pred_taken) ||
                   (upd_taken && (upd_target != upd_pred_target)));
    redirect_pc = (!RST && upd_taken) ? upd_target : upd_pc_plus4;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q   <= '0;
      tag_q     <= '0;
      target_q  <= '0;
      ctr_q     <= '0;
      is_cond_q <= '0;
    end else if (upd_en) begin
      if (up_hit) begin
        if (upd_is_cond) ctr_q[up_idx] <= up_ctr_next;
        if (upd_taken) begin
          target_q[up_idx]  <= upd_target;
          is_cond_q[up_idx] <= upd_is_cond;
        end
      end else if (upd_taken) begin
        // Direct mapped: a taken miss simply overwrites whatever lives at the index.
        valid_q[up_idx]   <= 1'b1;
        tag_q[up_idx]     <= up_tag;
        target_q[up_idx]  <= upd_target;
        is_cond_q[up_idx] <= upd_is_cond;
        ctr_q[up_idx]     <= CTR_WEAK;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_lookups <= '0;
      stat_mispred <= '0;
    end else begin
      if (lookup_en && (stat_lookups != STAT_MAX)) stat_lookups <= stat_lookups + STAT_W'(1);
      if (mispredict && (stat_mispred != STAT_MAX)) stat_mispred <= stat_mispred + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed vector bench for branch_predictor
// Two instances share stimulus: dynamic (MODE=1) and static not-taken (MODE=0).
module tb_branch_predictor;

  logic        CLK;
  logic        RST;
  logic        lookup_en;
  logic [31:0] lookup_pc;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_is_cond;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;

  logic        pt1, mis1, pt0, mis0;
  logic [31:0] ptg1, red1, ptg0, red0;
  logic [3:0]  sl1, sm1, sl0, sm0;

  branch_predictor #(.BTB_DEPTH(16), .CTR_BITS(2), .MODE(1), .STAT_W(4)) dut1 (
    .CLK(CLK), .RST(RST), .lookup_en(lookup_en), .lookup_pc(lookup_pc),
    .pred_taken(pt1), .pred_target(ptg1),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_is_cond(upd_is_cond), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mis1), .redirect_pc(red1), .stat_lookups(sl1), .stat_mispred(sm1)
  );

  branch_predictor #(.BTB_DEPTH(16), .CTR_BITS(2), .MODE(0), .STAT_W(4)) dut0 (
    .CLK(CLK), .RST(RST), .lookup_en(lookup_en), .lookup_pc(lookup_pc),
    .pred_taken(pt0), .pred_target(ptg0),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_is_cond(upd_is_cond), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mis0), .redirect_pc(red0), .stat_lookups(sl0), .stat_mispred(sm0)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        lk_en;
    logic [31:0] lk_pc;
    logic        up_en;
    logic [31:0] up_pc;
    logic        up_cond;
    logic        up_tk;
    logic [31:0] up_tgt;
    logic        up_ptk;
    logic [31:0] up_ptgt;
    logic        e_pt;
    logic [31:0] e_ptg;
    logic        e_mis;
    logic [31:0] e_red;
    logic [3:0]  e_sl;
    logic [3:0]  e_sm;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vt[20];

  function automatic vec_t mk(input logic lk_en, input logic [31:0] lk_pc,
                              input logic up_en, input logic [31:0] up_pc, input logic up_cond,
                              input logic up_tk, input logic [31:0] up_tgt, input logic up_ptk,
                              input logic [31:0] up_ptgt, input logic e_pt, input logic [31:0] e_ptg,
                              input logic e_mis, input logic [31:0] e_red,
                              input logic [3:0] e_sl, input logic [3:0] e_sm);
    vec_t v;
    v.lk_en = lk_en; v.lk_pc = lk_pc; v.up_en = up_en; v.up_pc = up_pc; v.up_cond = up_cond;
    v.up_tk = up_tk; v.up_tgt = up_tgt; v.up_ptk = up_ptk; v.up_ptgt = up_ptgt;
    v.e_pt = e_pt; v.e_ptg = e_ptg; v.e_mis = e_mis; v.e_red = e_red; v.e_sl = e_sl; v.e_sm = e_sm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic lk_en, input logic [31:0] lk_pc, input logic up_en,
                       input logic [31:0] up_pc, input logic up_cond, input logic up_tk,
                       input logic [31:0] up_tgt, input logic up_ptk, input logic [31:0] up_ptgt);
    lookup_en = lk_en; lookup_pc = lk_pc;
    upd_en = up_en; upd_pc = up_pc; upd_is_cond = up_cond; upd_taken = up_tk;
    upd_target = up_tgt; upd_pred_taken = up_ptk; upd_pred_target = up_ptgt;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    vt[0]  = mk(1, 32'h40, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   0, 32'h44,  0, 32'h4,   0, 0);
    vt[1]  = mk(0, 32'h0,  1, 32'h40, 1, 1, 32'h100, 0, 32'h44,  0, 32'h4,   1, 32'h100, 1, 0);
    vt[2]  = mk(1, 32'h40, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 32'h4,   1, 1);
    vt[3]  = mk(0, 32'h0,  1, 32'h40, 1, 0, 32'h0,   1, 32'h100, 0, 32'h4,   1, 32'h44,  2, 1);
    vt[4]  = mk(1, 32'h40, 1, 32'h40, 1, 0, 32'h0,   0, 32'h44,  0, 32'h44,  0, 32'h44,  2, 2);
    vt[5]  = mk(1, 32'h40, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   0, 32'h44,  0, 32'h4,   3, 2);
    vt[6]  = mk(1, 32'h80, 1, 32'h80, 1, 1, 32'h180, 0, 32'h84,  0, 32'h84,  1, 32'h180, 4, 2);
    vt[7]  = mk(1, 32'h80, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   1, 32'h180, 0, 32'h4,   5, 3);
    vt[8]  = mk(1, 32'h40, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   0, 32'h44,  0, 32'h4,   6, 3);
    vt[9]  = mk(0, 32'h0,  1, 32'hC0, 0, 1, 32'h200, 0, 32'hC4,  0, 32'h4,   1, 32'h200, 7, 3);
    vt[10] = mk(1, 32'hC0, 1, 32'hC0, 0, 1, 32'h300, 1, 32'h200, 1, 32'h200, 1, 32'h300, 7, 4);
    vt[11] = mk(1, 32'hC0, 1, 32'hC0, 0, 1, 32'h300, 1, 32'h300, 1, 32'h300, 0, 32'h300, 8, 5);
    vt[12] = mk(1, 32'h80, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   0, 32'h84,  0, 32'h4,   9, 5);
    vt[13] = mk(0, 32'h0,  1, 32'h44, 1, 1, 32'h400, 0, 32'h48,  0, 32'h4,   1, 32'h400, 10, 5);
    vt[14] = mk(0, 32'h0,  1, 32'h44, 1, 1, 32'h400, 1, 32'h400, 0, 32'h4,   0, 32'h400, 10, 6);
    vt[15] = mk(0, 32'h0,  1, 32'h44, 1, 1, 32'h400, 1, 32'h400, 0, 32'h4,   0, 32'h400, 10, 6);
    vt[16] = mk(1, 32'h44, 1, 32'h44, 1, 0, 32'h0,   1, 32'h400, 1, 32'h400, 1, 32'h48,  10, 6);
    vt[17] = mk(1, 32'h44, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   1, 32'h400, 0, 32'h4,   11, 7);
    vt[18] = mk(0, 32'h0,  1, 32'h44, 1, 0, 32'h0,   1, 32'h400, 0, 32'h4,   1, 32'h48,  12, 7);
    vt[19] = mk(1, 32'h44, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   0, 32'h48,  0, 32'h4,   12, 8);

    // Reset state with active requests that must be ignored.
    RST = 1'b1;
    drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'h100, 1'b0, 32'h44);
    @(negedge CLK); #1;
    chk("rst_pred_taken",  pt1,  0);
    chk("rst_pred_target", ptg1, 32'h44);
    chk("rst_mispredict",  mis1, 0);
    chk("rst_redirect",    red1, 32'h44);
    chk("rst_stat_lk",     sl1,  0);
    chk("rst_stat_mp",     sm1,  0);

    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(vt[i].lk_en, vt[i].lk_pc, vt[i].up_en, vt[i].up_pc, vt[i].up_cond,
            vt[i].up_tk, vt[i].up_tgt, vt[i].up_ptk, vt[i].up_ptgt);
      #1;
      chk($sformatf("v%0d_pred_taken", i),  pt1,  vt[i].e_pt);
      chk($sformatf("v%0d_pred_target", i), ptg1, vt[i].e_ptg);
      chk($sformatf("v%0d_mispredict", i),  mis1, vt[i].e_mis);
      chk($sformatf("v%0d_redirect", i),    red1, vt[i].e_red);
      chk($sformatf("v%0d_stat_lk", i),     sl1,  vt[i].e_sl);
      chk($sformatf("v%0d_stat_mp", i),     sm1,  vt[i].e_sm);
      @(negedge CLK);
    end
    idle(); #1;
    chk("tbl_end_stat_lk", sl1, 13);
    chk("tbl_end_stat_mp", sm1, 8);

    // Both statistics counters saturate at all-ones.
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      drive(1'b1, 32'h200, 1'b1, 32'h1000, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1004);
      #1;
      chk($sformatf("sat%0d_mispredict", i), mis1, 1);
    end
    @(negedge CLK);
    idle(); #1;
    chk("sat_stat_lk", sl1, 15);
    chk("sat_stat_mp", sm1, 15);

    // Reset mid-update: the allocation for 0x80 must be discarded.
    @(negedge CLK);
    drive(1'b1, 32'hC0, 1'b1, 32'h80, 1'b1, 1'b1, 32'h500, 1'b0, 32'h84);
    RST = 1'b1;
    #1;
    chk("mrst_mispredict", mis1, 0);
    chk("mrst_redirect",   red1, 32'h84);
    chk("mrst_pred_taken", pt1,  0);
    chk("mrst_stat_lk",    sl1,  0);
    chk("mrst_stat_mp",    sm1,  0);
    @(negedge CLK);
    RST = 1'b0;
    drive(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("mrst_lk80_taken",  pt1,  0);
    chk("mrst_lk80_target", ptg1, 32'h84);
    chk("mrst_stat_lk_hold", sl1, 0);
    @(negedge CLK);
    drive(1'b1, 32'hC0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("mrst_lkC0_taken", pt1, 0);
    chk("mrst_stat_lk_one", sl1, 1);

    // Static not-taken instance: table trains but never predicts taken.
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'h100, 1'b0, 32'h44);
      #1;
      chk($sformatf("m0_%0d_pred_taken", i),  pt0,  0);
      chk($sformatf("m0_%0d_pred_target", i), ptg0, 32'h44);
      chk($sformatf("m0_%0d_mispredict", i),  mis0, 1);
      chk($sformatf("m0_%0d_redirect", i),    red0, 32'h100);
    end
    @(negedge CLK);
    drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("m0_final_pred_taken", pt0, 0);
    chk("m0_stat_mp",          sm0, 3);
    chk("m1_same_pred_taken",  pt1, 1);
    chk("m1_same_pred_target", ptg1, 32'h100);

    @(negedge CLK);
    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
